// File: rtl/ascon_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ascon_seq_ctrl
// Description : Sequencer in front of the ASCON-128 encryption core. Accepts
//               one key/nonce command, then N_BLOCKS 64-bit words (word 0 is
//               associated data, the rest plaintext). Paces start and
//               data-valid pulses to the core's permutation timing, buffers
//               each cipher block for a valid/ready consumer, latches the tag
//               and flags a hung core through a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_seq_ctrl #(
  parameter int N_BLOCKS  = 4,
  parameter int INIT_WAIT = 14,
  parameter int BLK_WAIT  = 8,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 8
) (
  input  logic           clock_i,
  input  logic           reset_i,
  input  logic           cmd_valid_i,
  output logic           cmd_ready_o,
  input  logic [127:0]   key_i,
  input  logic [127:0]   nonce_i,
  input  logic [63:0]    msg_data_i,
  input  logic           msg_valid_i,
  output logic           msg_ready_o,
  output logic           core_start_o,
  output logic [63:0]    core_data_o,
  output logic           core_data_valid_o,
  output logic [127:0]   core_key_o,
  output logic [127:0]   core_nonce_o,
  input  logic [63:0]    core_cipher_i,
  input  logic           core_cipher_valid_i,
  input  logic [127:0]   core_tag_i,
  input  logic           core_end_i,
  output logic [63:0]    ct_data_o,
  output logic           ct_valid_o,
  input  logic           ct_ready_i,
  output logic [127:0]   tag_o,
  output logic           tag_valid_o,
  output logic           busy_o,
  output logic           error_o,
  input  logic           clear_i
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_INIT = 3'd2,
    FEED      = 3'd3,
    WAIT_CT   = 3'd4,
    WAIT_GAP  = 3'd5,
    WAIT_END  = 3'd6,
    ERROR     = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] INIT_LIM = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(BLK_WAIT - 1);
  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [3:0]       LAST_BLK = 4'(N_BLOCKS);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       blk_cnt;
  logic [3:0]       blk_inc;
  logic             cmd_fire;
  logic             msg_fire;
  logic             ct_fire;
  logic             cipher_take;
  logic             end_take;
  logic             watched;

  assign cmd_fire    = cmd_valid_i & cmd_ready_o;
  assign msg_fire    = msg_valid_i & msg_ready_o;
  assign ct_fire     = ct_valid_o & ct_ready_i;
  assign cipher_take = (state == WAIT_CT) & core_cipher_valid_i;
  assign end_take    = (state == WAIT_END) & core_end_i;
  assign watched     = (state == WAIT_INIT) | (state == WAIT_CT) |
                       (state == WAIT_GAP)  | (state == WAIT_END);

  // Saturating increments: counters stick at all-ones instead of wrapping
  assign cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
  assign blk_inc = (blk_cnt == 4'hF) ? blk_cnt : blk_cnt + 4'd1;

  // Next-state decode; the watchdog overrides any state that would otherwise hold
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (cmd_fire) nxt = START;
      START:     nxt = WAIT_INIT;
      // WAIT_INIT lasts INIT_WAIT cycles (counter 0..INIT_WAIT-1); a cipher
      // block still pending from the previous message also holds it off.
      WAIT_INIT: if ((wait_cnt >= INIT_LIM) && !ct_valid_o) nxt = FEED;
      FEED:      if (msg_fire) nxt = (blk_cnt == 4'd0) ? WAIT_GAP : WAIT_CT;
      WAIT_CT:   if (core_cipher_valid_i) nxt = (blk_cnt == LAST_BLK) ? WAIT_END : WAIT_GAP;
      // A full cipher buffer stalls the core so no block is ever dropped
      WAIT_GAP:  if ((wait_cnt >= GAP_LIM) && !ct_valid_o) nxt = FEED;
      WAIT_END:  if (core_end_i) nxt = IDLE;
      ERROR:     if (clear_i) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (watched && (nxt == state) && (wait_cnt >= TO_LIM)) begin
      nxt = ERROR;
    end
  end

  // Control FSM with registered outputs, datapath latches and cipher/tag buffers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      blk_cnt           <= '0;
      cmd_ready_o       <= 1'b0;
      msg_ready_o       <= 1'b0;
      busy_o            <= 1'b0;
      error_o           <= 1'b0;
      core_start_o      <= 1'b0;
      core_data_valid_o <= 1'b0;
      core_data_o       <= '0;
      core_key_o        <= '0;
      core_nonce_o      <= '0;
      ct_data_o         <= '0;
      ct_valid_o        <= 1'b0;
      tag_o             <= '0;
      tag_valid_o       <= 1'b0;
    end else begin
      state             <= nxt;
      cmd_ready_o       <= (nxt == IDLE);
      msg_ready_o       <= (nxt == FEED);
      busy_o            <= (nxt != IDLE);
      error_o           <= (nxt == ERROR);
      core_start_o      <= (nxt == START);
      core_data_valid_o <= msg_fire;

      // Every state change restarts the wait/watchdog counter
      if (nxt != state) begin
        wait_cnt <= '0;
      end else if (watched) begin
        wait_cnt <= cnt_inc;
      end

      if (cmd_fire) begin
        core_key_o   <= key_i;
        core_nonce_o <= nonce_i;
        tag_valid_o  <= 1'b0;
        blk_cnt      <= '0;
      end

      if (msg_fire) begin
        core_data_o <= msg_data_i;
        blk_cnt     <= blk_inc;
      end

      if (cipher_take) begin
        ct_data_o  <= core_cipher_i;
        ct_valid_o <= 1'b1;
      end else if (ct_fire) begin
        ct_valid_o <= 1'b0;
      end

      if (end_take) begin
        tag_o       <= core_tag_i;
        tag_valid_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascon_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_seq_ctrl
// Description : Directed self-checking bench for ascon_seq_ctrl with a small
//               behavioural stand-in for the ASCON core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_seq_ctrl;

  localparam int          N_BLK = 4;
  localparam logic [63:0] MASK  = 64'hDEAD_BEEF_0123_4567;

  logic         clock_i = 1'b0;
  logic         reset_i;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [127:0] key_i;
  logic [127:0] nonce_i;
  logic [63:0]  msg_data_i;
  logic         msg_valid_i;
  logic         msg_ready_o;
  logic         core_start_o;
  logic [63:0]  core_data_o;
  logic         core_data_valid_o;
  logic [127:0] core_key_o;
  logic [127:0] core_nonce_o;
  logic [63:0]  core_cipher_i;
  logic         core_cipher_valid_i;
  logic [127:0] core_tag_i;
  logic         core_end_i;
  logic [63:0]  ct_data_o;
  logic         ct_valid_o;
  logic         ct_ready_i;
  logic [127:0] tag_o;
  logic         tag_valid_o;
  logic         busy_o;
  logic         error_o;
  logic         clear_i;

  ascon_seq_ctrl dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .cmd_valid_i         (cmd_valid_i),
    .cmd_ready_o         (cmd_ready_o),
    .key_i               (key_i),
    .nonce_i             (nonce_i),
    .msg_data_i          (msg_data_i),
    .msg_valid_i         (msg_valid_i),
    .msg_ready_o         (msg_ready_o),
    .core_start_o        (core_start_o),
    .core_data_o         (core_data_o),
    .core_data_valid_o   (core_data_valid_o),
    .core_key_o          (core_key_o),
    .core_nonce_o        (core_nonce_o),
    .core_cipher_i       (core_cipher_i),
    .core_cipher_valid_i (core_cipher_valid_i),
    .core_tag_i          (core_tag_i),
    .core_end_i          (core_end_i),
    .ct_data_o           (ct_data_o),
    .ct_valid_o          (ct_valid_o),
    .ct_ready_i          (ct_ready_i),
    .tag_o               (tag_o),
    .tag_valid_o         (tag_valid_o),
    .busy_o              (busy_o),
    .error_o             (error_o),
    .clear_i             (clear_i)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  // Event log, sampled on the falling edge
  int          start_q[$];
  int          vld_q[$];
  logic [63:0] vdat_q[$];
  logic [63:0] ct_q[$];
  int          err_cyc = -1;

  always @(negedge clock_i) begin
    if (core_start_o) start_q.push_back(cyc);
    if (core_data_valid_o) begin
      vld_q.push_back(cyc);
      vdat_q.push_back(core_data_o);
    end
    if (ct_valid_o && ct_ready_i) ct_q.push_back(ct_data_o);
    if (error_o && err_cyc < 0) err_cyc = cyc;
  end

  // Core stand-in: answers each plaintext block one cycle after its valid
  // pulse with data^MASK, and ends the message one cycle after the last
  // cipher with tag = key^nonce.
  logic core_en = 1'b1;
  int   nvld    = 0;
  logic end_pend = 1'b0;
  always @(negedge clock_i) begin
    core_cipher_valid_i = 1'b0;
    core_end_i          = 1'b0;
    if (reset_i || core_start_o) begin
      nvld     = 0;
      end_pend = 1'b0;
    end else if (core_data_valid_o) begin
      if (nvld > 0 && core_en) begin
        core_cipher_valid_i = 1'b1;
        core_cipher_i       = core_data_o ^ MASK;
        if (nvld == N_BLK - 1) end_pend = 1'b1;
      end
      nvld = nvld + 1;
    end else if (end_pend) begin
      core_end_i = 1'b1;
      core_tag_i = core_key_o ^ core_nonce_o;
      end_pend   = 1'b0;
    end
  end

  // Message source: next word presented after each accepted word
  logic [63:0] words [4];
  logic [2:0]  widx = 3'd0;
  always @(posedge clock_i) begin
    if (core_start_o) widx <= 3'd0;
    else if (msg_valid_i && msg_ready_o) widx <= widx + 3'd1;
  end
  assign msg_data_i = (widx < 3'd4) ? words[widx[1:0]] : 64'h0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic clear_q();
    start_q.delete();
    vld_q.delete();
    vdat_q.delete();
    ct_q.delete();
  endtask

  task automatic set_words(input logic [63:0] base);
    for (int i = 0; i < 4; i++) words[i] = base ^ 64'(i * 32'h0101_0101);
  endtask

  task automatic send_cmd(input logic [127:0] k, input logic [127:0] n);
    key_i       = k;
    nonce_i     = n;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_vld(input int n, input int budget);
    int c = 0;
    while (vld_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("wait_vld", 128'(vld_q.size() >= n), 128'(1));
  endtask

  task automatic wait_tag(input int budget);
    int c = 0;
    while (!tag_valid_o && c < budget) begin
      tick();
      c++;
    end
    chk("wait_tag", 128'(tag_valid_o), 128'(1));
  endtask

  // Full nominal message with ct_ready_i=1:
  //   START at s; WAIT_INIT s+1..s+14 (INIT_WAIT cycles); FEED s+15;
  //   AD handshake -> valid at s+16. AD gap: WAIT_GAP 8 cycles + FEED -> +9.
  //   Plaintext: WAIT_CT 1 cycle (core answers next cycle) + 8 + FEED -> +10.
  task automatic check_full(input logic [127:0] k, input logic [127:0] n);
    int exp_d[4];
    exp_d = '{16, 25, 35, 45};
    chk("start_cnt", 128'(start_q.size()), 128'(1));
    chk("vld_cnt", 128'(vld_q.size()), 128'(N_BLK));
    for (int i = 0; i < vld_q.size() && i < 4 && start_q.size() > 0; i++) begin
      chk("vld_delay", 128'(vld_q[i] - start_q[0]), 128'(exp_d[i]));
      chk("vld_data", 128'(vdat_q[i]), 128'(words[i]));
    end
    chk("ct_cnt", 128'(ct_q.size()), 128'(N_BLK - 1));
    for (int i = 0; i < ct_q.size() && i < 3; i++) begin
      chk("ct_data", 128'(ct_q[i]), 128'(words[i+1] ^ MASK));
    end
    chk("tag", tag_o, k ^ n);
    chk("busy_end", 128'(busy_o), 128'(0));
    chk("cmd_ready_end", 128'(cmd_ready_o), 128'(1));
  endtask

  logic any_out;
  assign any_out = cmd_ready_o | msg_ready_o | core_start_o | (|core_data_o) |
                   core_data_valid_o | (|core_key_o) | (|core_nonce_o) |
                   (|ct_data_o) | ct_valid_o | (|tag_o) | tag_valid_o |
                   busy_o | error_o;

  localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] N1 = 128'h101112131415161718191A1B1C1D1E1F;

  initial begin
    logic [63:0] snap;
    int          nv;
    int          bad;
    int          rel;
    int          c;

    reset_i     = 1'b1;
    cmd_valid_i = 1'b0;
    key_i       = '0;
    nonce_i     = '0;
    msg_valid_i = 1'b1;
    ct_ready_i  = 1'b1;
    clear_i     = 1'b0;

    // 1. Reset
    repeat (3) @(negedge clock_i);
    chk("rst_outs", 128'(any_out), 128'(0));
    @(posedge clock_i);
    #1 reset_i = 1'b0;
    tick();
    chk("rst_cmd_ready", 128'(cmd_ready_o), 128'(1));
    chk("rst_busy", 128'(busy_o), 128'(0));

    // 2. Nominal message
    set_words(64'h1111_2222_3333_4444);
    clear_q();
    send_cmd(K1, N1);
    chk("nom_busy", 128'(busy_o), 128'(1));
    wait_tag(200);
    check_full(K1, N1);

    // 3. Backpressure on the cipher buffer
    ct_ready_i = 1'b0;
    set_words(64'hA0A1_A2A3_A4A5_A6A7);
    clear_q();
    send_cmd(~K1, N1);
    chk("bp_tagv_clr", 128'(tag_valid_o), 128'(0));
    c = 0;
    while (!ct_valid_o && c < 100) begin
      tick();
      c++;
    end
    chk("bp_ct_seen", 128'(ct_valid_o), 128'(1));
    snap = ct_data_o;
    nv   = vld_q.size();
    bad  = 0;
    repeat (40) begin
      tick();
      if (ct_data_o !== snap || !ct_valid_o || msg_ready_o) bad++;
    end
    chk("bp_stall", 128'(bad), 128'(0));
    chk("bp_no_vld", 128'(vld_q.size()), 128'(nv));
    chk("bp_ct_data", 128'(snap), 128'(words[1] ^ MASK));
    rel = cyc;
    ct_ready_i = 1'b1;
    tick();
    chk("bp_ct_clr", 128'(ct_valid_o), 128'(0));
    wait_vld(3, 50);
    // handshake at rel+1, FEED at rel+2, next valid pulse at rel+3
    if (vld_q.size() >= 3) chk("bp_resume", 128'(vld_q[2] - rel), 128'(3));
    wait_tag(200);
    chk("bp_ct_cnt", 128'(ct_q.size()), 128'(3));
    for (int i = 0; i < ct_q.size() && i < 3; i++) begin
      chk("bp_ct_order", 128'(ct_q[i]), 128'(words[i+1] ^ MASK));
    end
    chk("bp_tag", tag_o, ~K1 ^ N1);

    // 4. Watchdog: core never returns a cipher
    core_en = 1'b0;
    err_cyc = -1;
    clear_q();
    set_words(64'h0F0E_0D0C_0B0A_0908);
    send_cmd(K1, ~N1);
    wait_vld(2, 100);
    c = 0;
    while (err_cyc < 0 && c < 400) begin
      tick();
      c++;
    end
    chk("wd_seen", 128'(err_cyc >= 0), 128'(1));
    if (vld_q.size() >= 2) chk("wd_time", 128'(err_cyc - vld_q[1]), 128'(255));
    chk("wd_error", 128'(error_o), 128'(1));
    chk("wd_cmd_ready", 128'(cmd_ready_o), 128'(0));
    chk("wd_ct", 128'(ct_valid_o), 128'(0));
    tick();
    chk("wd_sticky", 128'(error_o), 128'(1));
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("wd_clr_err", 128'(error_o), 128'(0));
    chk("wd_clr_ready", 128'(cmd_ready_o), 128'(1));
    chk("wd_clr_busy", 128'(busy_o), 128'(0));
    core_en = 1'b1;

    // 5. Reset during WAIT_GAP after block 2, then a full message
    set_words(64'h5555_6666_7777_8888);
    clear_q();
    send_cmd(N1, K1);
    wait_vld(3, 100);
    tick();
    chk("mid_busy", 128'(busy_o), 128'(1));
    chk("mid_gap", 128'(msg_ready_o), 128'(0));
    reset_i = 1'b1;
    #1;
    chk("mid_rst_outs", 128'(any_out), 128'(0));
    tick();
    reset_i = 1'b0;
    tick();
    chk("mid_rst_ready", 128'(cmd_ready_o), 128'(1));
    set_words(64'h1357_9BDF_2468_ACE0);
    clear_q();
    send_cmd(K1 ^ N1, N1);
    wait_tag(200);
    check_full(K1 ^ N1, N1);

    // 6. Command while busy is ignored
    set_words(64'hCAFE_F00D_BEEF_0001);
    clear_q();
    send_cmd(K1, N1);
    cmd_valid_i = 1'b1;
    key_i       = ~K1;
    nonce_i     = ~N1;
    repeat (10) tick();
    chk("busy_cmd_ready", 128'(cmd_ready_o), 128'(0));
    chk("busy_key", core_key_o, K1);
    cmd_valid_i = 1'b0;
    wait_tag(200);
    check_full(K1, N1);
    chk("busy_key_end", core_key_o, K1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
